// File: rtl/adc_sample_ctrl.sv
// Trigger-decimated serial ADC sequencer: convst pulse, busy wait, SPI-style readout.
// Define ADC_AVG_EN to average results in pairs before presenting them on sample.
module adc_sample_ctrl #(
    parameter int DATA_W   = 12,
    parameter int SCLK_DIV = 2,
    parameter int CONV_W   = 4,
    parameter int BUSY_TO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_trig,
    input  logic [3:0]        decim,
    input  logic              adc_busy,
    input  logic              adc_sdo,
    output logic              adc_convst,
    output logic              adc_cs_n,
    output logic              adc_sclk,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              overrun,
    output logic              timeout
);

    localparam int TMR_MAX = (BUSY_TO > CONV_W)
                           ? ((BUSY_TO > SCLK_DIV) ? BUSY_TO : SCLK_DIV)
                           : ((CONV_W > SCLK_DIV) ? CONV_W : SCLK_DIV);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CONVST, WAIT_BUSY, SHIFT, DONE} state_t;

    state_t            state, state_n;
    logic [2:0]        trig_sr;
    logic              busy_meta, busy_sync;
    logic [TMR_W-1:0]  tmr, tmr_n;
    logic [BIT_W-1:0]  bits, bits_n;
    logic              phase, phase_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [3:0]        trig_cnt, trig_cnt_n;
    logic [3:0]        cnt_inc, dec_eff;
    logic              edge_det, to_n;

`ifdef ADC_AVG_EN
    logic [DATA_W-1:0] acc;
    logic              half;
    logic [DATA_W:0]   sum;
    assign sum = {1'b0, acc} + {1'b0, shreg};
`endif

    assign edge_det = (trig_sr[2:1] == 2'b01);
    assign cnt_inc  = trig_cnt + 4'd1;
    assign dec_eff  = (decim == 4'd0) ? 4'd1 : decim;

    always_comb begin
        state_n    = state;
        tmr_n      = tmr;
        bits_n     = bits;
        phase_n    = phase;
        shreg_n    = shreg;
        trig_cnt_n = trig_cnt;
        to_n       = 1'b0;
        case (state)
            IDLE: begin
                if (edge_det) begin
                    if (cnt_inc >= dec_eff) begin
                        trig_cnt_n = '0;
                        tmr_n      = '0;
                        state_n    = CONVST;
                    end else begin
                        trig_cnt_n = cnt_inc;
                    end
                end
            end
            CONVST: begin
                if (tmr == TMR_W'(CONV_W - 1)) begin
                    tmr_n   = '0;
                    state_n = WAIT_BUSY;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            WAIT_BUSY: begin
                // tmr != 0 enforces the two-cycle minimum before busy is trusted
                if (tmr != '0 && !busy_sync) begin
                    tmr_n   = '0;
                    bits_n  = '0;
                    phase_n = 1'b0;
                    state_n = SHIFT;
                end else if (tmr == TMR_W'(BUSY_TO - 1)) begin
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            SHIFT: begin
                if (tmr == TMR_W'(SCLK_DIV - 1)) begin
                    tmr_n   = '0;
                    phase_n = !phase;
                    if (!phase) begin
                        shreg_n = {shreg[DATA_W-2:0], adc_sdo};
                    end else if (bits == BIT_W'(DATA_W - 1)) begin
                        state_n = DONE;
                    end else begin
                        bits_n = bits + 1'b1;
                    end
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_sr      <= '0;
            busy_meta    <= 1'b0;
            busy_sync    <= 1'b0;
            state        <= IDLE;
            tmr          <= '0;
            bits         <= '0;
            phase        <= 1'b0;
            shreg        <= '0;
            trig_cnt     <= '0;
            adc_convst   <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_sclk     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
`ifdef ADC_AVG_EN
            acc          <= '0;
            half         <= 1'b0;
`endif
        end else begin
            trig_sr      <= {trig_sr[1:0], adc_trig};
            busy_meta    <= adc_busy;
            busy_sync    <= busy_meta;
            state        <= state_n;
            tmr          <= tmr_n;
            bits         <= bits_n;
            phase        <= phase_n;
            shreg        <= shreg_n;
            trig_cnt     <= trig_cnt_n;
            // Outputs are decoded from next-state values so they are registered yet aligned with state
            adc_convst   <= (state_n == CONVST);
            adc_cs_n     <= (state_n != SHIFT);
            adc_sclk     <= (state_n == SHIFT) ? phase_n : 1'b1;
            overrun      <= edge_det && (state != IDLE);
            timeout      <= to_n;
            sample_valid <= 1'b0;
`ifdef ADC_AVG_EN
            if (state_n == DONE) begin
                if (half) begin
                    sample       <= sum[DATA_W:1];
                    sample_valid <= 1'b1;
                    half         <= 1'b0;
                end else begin
                    acc  <= shreg;
                    half <= 1'b1;
                end
            end
            if (to_n) begin
                half <= 1'b0;
            end
`else
            if (state_n == DONE) begin
                sample       <= shreg;
                sample_valid <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Directed bench for adc_sample_ctrl with a behavioural ADC (busy + serial data) model.
module tb_adc_sample_ctrl;

    localparam int DATA_W   = 12;
    localparam int SCLK_DIV = 2;
    localparam int CONV_W   = 4;
    localparam int BUSY_TO  = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              adc_trig = 1'b0;
    logic [3:0]        decim = 4'd1;
    logic              adc_busy = 1'b0;
    logic              adc_sdo = 1'b0;
    logic              adc_convst, adc_cs_n, adc_sclk;
    logic [DATA_W-1:0] sample;
    logic              sample_valid, overrun, timeout;

    adc_sample_ctrl #(
        .DATA_W  (DATA_W),
        .SCLK_DIV(SCLK_DIV),
        .CONV_W  (CONV_W),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_trig    (adc_trig),
        .decim       (decim),
        .adc_busy    (adc_busy),
        .adc_sdo     (adc_sdo),
        .adc_convst  (adc_convst),
        .adc_cs_n    (adc_cs_n),
        .adc_sclk    (adc_sclk),
        .sample      (sample),
        .sample_valid(sample_valid),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // ADC model: busy for 10 cycles after convst rises; sdo updated after each sclk fall
    logic [DATA_W-1:0] word = '0;
    bit  hold_busy = 1'b0;
    int  idx = DATA_W - 1;
    int  busy_cnt = 0;
    logic m_cs = 1'b1, m_sclk = 1'b1, m_conv = 1'b0;

    always @(posedge clk) begin
        #1;
        if (adc_convst && !m_conv) busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        adc_busy = hold_busy || (busy_cnt > 0);
        if (!adc_cs_n && m_cs) idx = DATA_W - 1;
        else if (!adc_cs_n && m_sclk && !adc_sclk && idx > 0) idx--;
        adc_sdo = word[idx];
        m_cs   = adc_cs_n;
        m_sclk = adc_sclk;
        m_conv = adc_convst;
    end

    int conv_cnt = 0, conv_rise_cyc = 0, conv_fall_cyc = 0, conv_w = 0;
    int valid_cnt = 0, ovr_cnt = 0, to_cnt = 0, to_cyc = 0, sclk_rise = 0;
    logic p_conv = 1'b0, p_sclk = 1'b1;

    always @(negedge clk) begin
        if (adc_convst && !p_conv) begin
            conv_cnt++;
            conv_rise_cyc = cyc;
            conv_w = 0;
        end
        if (adc_convst) conv_w++;
        if (!adc_convst && p_conv) conv_fall_cyc = cyc;
        if (sample_valid) valid_cnt++;
        if (overrun) ovr_cnt++;
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (adc_sclk && !p_sclk && !adc_cs_n) sclk_rise++;
        p_conv = adc_convst;
        p_sclk = adc_sclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic pulse_trig(output int t0);
        @(posedge clk);
        #1 adc_trig = 1'b1;
        t0 = cyc;
        repeat (2) @(posedge clk);
        #1 adc_trig = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_valid(input int base, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (valid_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs(input logic level, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (adc_cs_n === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({adc_convst, adc_cs_n, adc_sclk, sample_valid, overrun, timeout} !== 6'b011000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {adc_convst, adc_cs_n, adc_sclk, sample_valid, overrun, timeout}, 6'b011000);
        end
        checks++;
        if (sample !== 12'h000) begin
            errors++;
            $display("FAIL reset_sample: got %h expected %h", sample, 12'h000);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single();
        int t0, cb, vb, sb;
        bit ok;
        word = 12'hA5C;
        decim = 4'd1;
        cb = conv_cnt; vb = valid_cnt; sb = sclk_rise;
        pulse_trig(t0);
        wait_valid(vb, 200, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL single_valid_wait: got %b expected %b", ok, 1'b1);
        end
        checks++;
        if (conv_rise_cyc !== t0 + 3) begin
            errors++;
            $display("FAIL single_convst_latency: got %0d expected %0d", conv_rise_cyc - t0, 3);
        end
        checks++;
        if (conv_w !== CONV_W) begin
            errors++;
            $display("FAIL single_convst_width: got %0d expected %0d", conv_w, CONV_W);
        end
        checks++;
        if (sample !== 12'hA5C) begin
            errors++;
            $display("FAIL single_sample: got %h expected %h", sample, 12'hA5C);
        end
        checks++;
        if (valid_cnt - vb !== 1) begin
            errors++;
            $display("FAIL single_valid_count: got %0d expected %0d", valid_cnt - vb, 1);
        end
        checks++;
        if (sclk_rise - sb !== DATA_W) begin
            errors++;
            $display("FAIL single_sclk_periods: got %0d expected %0d", sclk_rise - sb, DATA_W);
        end
        checks++;
        if (conv_cnt - cb !== 1) begin
            errors++;
            $display("FAIL single_conv_count: got %0d expected %0d", conv_cnt - cb, 1);
        end
    endtask

    task automatic test_decim();
        int t0, cb, vb, exp_conv;
        bit ok;
        word = 12'h123;
        decim = 4'd3;
        cb = conv_cnt; vb = valid_cnt;
        for (int i = 1; i <= 6; i++) begin
            pulse_trig(t0);
            repeat (4) @(negedge clk);
            exp_conv = i / 3;
            checks++;
            if (conv_cnt - cb !== exp_conv) begin
                errors++;
                $display("FAIL decim_edge%0d_convs: got %0d expected %0d", i, conv_cnt - cb, exp_conv);
            end
            if (i % 3 == 0) begin
                wait_valid(valid_cnt, 200, ok);
                checks++;
                if (ok !== 1'b1) begin
                    errors++;
                    $display("FAIL decim_valid_wait%0d: got %b expected %b", i, ok, 1'b1);
                end
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (valid_cnt - vb !== 2) begin
            errors++;
            $display("FAIL decim_valid_count: got %0d expected %0d", valid_cnt - vb, 2);
        end
        checks++;
        if (sample !== 12'h123) begin
            errors++;
            $display("FAIL decim_sample: got %h expected %h", sample, 12'h123);
        end
        decim = 4'd1;
    endtask

    task automatic test_overrun();
        int t0, cb, vb, ob;
        bit ok, ok2;
        word = 12'h3C7;
        decim = 4'd1;
        cb = conv_cnt; vb = valid_cnt; ob = ovr_cnt;
        pulse_trig(t0);
        wait_cs(1'b0, 100, ok);
        pulse_trig(t0);
        wait_valid(vb, 200, ok2);
        repeat (10) @(negedge clk);
        checks++;
        if ({ok, ok2} !== 2'b11) begin
            errors++;
            $display("FAIL overrun_waits: got %b expected %b", {ok, ok2}, 2'b11);
        end
        checks++;
        if (ovr_cnt - ob !== 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d expected %0d", ovr_cnt - ob, 1);
        end
        checks++;
        if (sample !== 12'h3C7) begin
            errors++;
            $display("FAIL overrun_sample: got %h expected %h", sample, 12'h3C7);
        end
        checks++;
        if ({conv_cnt - cb, valid_cnt - vb} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL overrun_conv_valid: got %0d/%0d expected 1/1", conv_cnt - cb, valid_cnt - vb);
        end
    endtask

    task automatic test_timeout();
        int t0, vb, sb, tb0;
        bit ok;
        hold_busy = 1'b1;
        decim = 4'd1;
        vb = valid_cnt; sb = sclk_rise; tb0 = to_cnt;
        pulse_trig(t0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (to_cnt > tb0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait: got %b expected %b", ok, 1'b1);
        end
        checks++;
        if (conv_fall_cyc !== t0 + 3 + CONV_W) begin
            errors++;
            $display("FAIL timeout_wait_entry: got %0d expected %0d", conv_fall_cyc - t0, 3 + CONV_W);
        end
        checks++;
        if (to_cyc !== conv_fall_cyc + BUSY_TO) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", to_cyc - conv_fall_cyc, BUSY_TO);
        end
        checks++;
        if ({to_cnt - tb0, valid_cnt - vb, sclk_rise - sb} !== {32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL timeout_effects: got to=%0d valid=%0d sclk=%0d expected 1/0/0",
                     to_cnt - tb0, valid_cnt - vb, sclk_rise - sb);
        end
        checks++;
        if (sample !== 12'h3C7) begin
            errors++;
            $display("FAIL timeout_sample_kept: got %h expected %h", sample, 12'h3C7);
        end
        hold_busy = 1'b0;
        repeat (15) @(posedge clk);
    endtask

    task automatic test_reset_shift();
        int t0, vb, sb;
        bit ok, ok2;
        word = 12'h7FF;
        decim = 4'd1;
        pulse_trig(t0);
        wait_cs(1'b0, 100, ok);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({ok, adc_cs_n, adc_sclk} !== 3'b111) begin
            errors++;
            $display("FAIL rstshift_immediate: got %b expected %b", {ok, adc_cs_n, adc_sclk}, 3'b111);
        end
        checks++;
        if (sample !== 12'h000) begin
            errors++;
            $display("FAIL rstshift_sample_clear: got %h expected %h", sample, 12'h000);
        end
        vb = valid_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (valid_cnt - vb !== 0) begin
            errors++;
            $display("FAIL rstshift_no_valid: got %0d expected %0d", valid_cnt - vb, 0);
        end
        word = 12'hE19;
        vb = valid_cnt; sb = sclk_rise;
        pulse_trig(t0);
        wait_valid(vb, 200, ok2);
        checks++;
        if (ok2 !== 1'b1) begin
            errors++;
            $display("FAIL rstshift_valid_wait: got %b expected %b", ok2, 1'b1);
        end
        checks++;
        if (sample !== 12'hE19) begin
            errors++;
            $display("FAIL rstshift_sample: got %h expected %h", sample, 12'hE19);
        end
        checks++;
        if (sclk_rise - sb !== DATA_W) begin
            errors++;
            $display("FAIL rstshift_sclk_periods: got %0d expected %0d", sclk_rise - sb, DATA_W);
        end
    endtask

    task automatic test_avg();
        int t0, vb;
        bit ok, ok2, ok3;
        decim = 4'd1;
        vb = valid_cnt;
        word = 12'h100;
        pulse_trig(t0);
        wait_cs(1'b0, 100, ok);
        wait_cs(1'b1, 100, ok2);
        repeat (5) @(negedge clk);
        checks++;
        if ({ok, ok2, valid_cnt - vb} !== {2'b11, 32'd0}) begin
            errors++;
            $display("FAIL avg_first_half: got waits=%b valid=%0d expected 11/0", {ok, ok2}, valid_cnt - vb);
        end
        word = 12'h203;
        pulse_trig(t0);
        wait_valid(vb, 200, ok3);
        repeat (5) @(negedge clk);
        checks++;
        if (ok3 !== 1'b1) begin
            errors++;
            $display("FAIL avg_valid_wait: got %b expected %b", ok3, 1'b1);
        end
        checks++;
        if (sample !== 12'h181) begin
            errors++;
            $display("FAIL avg_sample: got %h expected %h", sample, 12'h181);
        end
        checks++;
        if (valid_cnt - vb !== 1) begin
            errors++;
            $display("FAIL avg_valid_count: got %0d expected %0d", valid_cnt - vb, 1);
        end
    endtask

    initial begin
        test_reset();
`ifdef ADC_AVG_EN
        test_avg();
`else
        test_single();
        test_decim();
        test_overrun();
        test_timeout();
        test_reset_shift();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_ctrl.md
ADC_SAMPLE_CTRL -- requirements
Module: adc_sample_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 12: ADC result width and serial bit count.
REQ-002 SHALL have parameter SCLK_DIV, default 2: number of clk cycles in each adc_sclk half-period (≥1).
REQ-003 SHALL have parameter CONV_W, default 4: width of the adc_convst pulse in clk cycles (≥1).
REQ-004 SHALL have parameter BUSY_TO, default 255: timeout in clk cycles for WAIT_BUSY.
REQ-005 SHALL have port clk  in  1  single clock; all logic is on the posedge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port adc_trig  in  1  sample trigger from the ramp-compare ADC trigger stage.
REQ-008 SHALL have port decim  in  4  triggers per conversion; 0 is treated as 1.
REQ-009 SHALL have port adc_busy  in  1  ADC busy flag (asynchronous).
REQ-010 SHALL have port adc_sdo  in  1  ADC serial data, MSB first.
REQ-011 SHALL have port adc_convst  out  1  conversion start.
REQ-012 SHALL have port adc_cs_n  out  1  chip select, active low.
REQ-013 SHALL have port adc_sclk  out  1  serial clock, idles high.
REQ-014 SHALL have port sample  out  DATA_W  last result.
REQ-015 SHALL have port sample_valid  out  1  one-cycle strobe that qualifies sample.
REQ-016 SHALL have port overrun  out  1  one-cycle pulse when a trigger edge is dropped.
REQ-017 SHALL have port timeout  out  1  one-cycle pulse when a busy wait is aborted.

Function
REQ-018 SHALL pass adc_trig through a 3-bit shift register; a rising edge is detected when bits [2:1] equal 01.
REQ-019 SHALL pass adc_busy through a 2-FF synchronizer before use.
REQ-020 SHALL implement FSM states IDLE, CONVST, WAIT_BUSY, SHIFT, DONE; all outputs SHALL be registered.
REQ-021 In IDLE, each detected edge SHALL increment the 4-bit trigger count. When the incremented count ≥ max(decim,1), the count SHALL clear and the FSM SHALL enter CONVST on the same edge.
REQ-022 decim SHALL be compared live; if it is lowered below the current count, the next edge SHALL fire.
REQ-023 adc_convst SHALL rise on the 3rd clk posedge after adc_trig is first sampled high (decim=1) and SHALL be held for exactly CONV_W cycles; the FSM SHALL then enter WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL last at least 2 cycles and SHALL exit to SHIFT on the first later cycle with synchronized busy=0.
REQ-025 After BUSY_TO cycles in WAIT_BUSY, the FSM SHALL pulse timeout, leave sample unchanged, and return to IDLE.
REQ-026 In SHIFT, adc_cs_n SHALL be 0 and adc_sclk SHALL run DATA_W periods, each SCLK_DIV cycles low then SCLK_DIV cycles high.
REQ-027 adc_sdo SHALL be captured MSB first on the clk cycle in which adc_sclk goes 0->1.
REQ-028 In DONE, the FSM SHALL drive cs_n=1 and sclk=1, load sample, pulse sample_valid for 1 cycle, and return to IDLE.
REQ-029 A trigger edge detected in any state other than IDLE SHALL pulse overrun for 1 cycle and SHALL NOT be counted.

Reset
REQ-030 rst SHALL immediately force adc_convst=0, adc_cs_n=1, adc_sclk=1, sample=0, and sample_valid=overrun=timeout=0. It SHALL also clear the state (to IDLE), trigger count, bit count, synchronizers and average accumulator.
REQ-031 Reset during SHIFT or CONVST SHALL abort the transfer with no sample_valid; operation SHALL resume on the first trigger edge after release.

Configuration
REQ-032 Macro ADC_AVG_EN: when defined, results SHALL be averaged in pairs. sample SHALL equal (first+second)>>1, computed with a DATA_W+1-bit sum and truncated, and sample_valid SHALL assert only after every second DONE.
REQ-033 When ADC_AVG_EN is undefined, every DONE SHALL produce sample_valid with the raw result and no accumulator SHALL exist.
REQ-034 With ADC_AVG_EN defined, a timeout SHALL discard any pending first half of the pair.

Verification
REQ-035 Scenario: decim=1, single adc_trig pulse, busy low after 10 cycles, sdo pattern 0xA5C -> convst rises at posedge 3, is CONV_W=4 wide, sample=0xA5C, one sample_valid.
REQ-036 Scenario: decim=3, 6 trigger edges -> exactly 2 conversions, starting on edges 3 and 6.
REQ-037 Scenario: trigger edge during SHIFT -> one overrun pulse; the transfer completes with the correct sample.
REQ-038 Scenario: adc_busy held high -> timeout pulse BUSY_TO cycles after WAIT_BUSY entry; FSM returns to IDLE with no sample_valid.
REQ-039 Scenario: rst asserted mid-SHIFT -> cs_n=1 and sclk=1 immediately; the next trigger yields a correct full conversion.
REQ-040 Scenario: ADC_AVG_EN defined, results 0x100 then 0x203 -> single sample_valid with sample=0x181.
